uart_tx_feeder: RTL
===================

Name: uart_tx_feeder

Overview:
- Buffered front end for the UART transmit path. Sits directly upstream of the UART TX_START/data_in pins.
- Accepts words from a host-side write port into a FIFO. Pops one word at a time, presents it on tx_data and issues a one-cycle tx_start pulse.
- The transmitter exposes no busy flag, so the block enforces frame spacing with its own frame timer derived from clock and baud parameters.

Parameters:
- DATA_SIZE, 7: word width; must match the UART instance.
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- BAUD_RATE, 9600: line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer truncation.
- STOP_BITS, 1: stop bits counted in frame time (1 or 2).
- GAP_CLKS, 0: extra idle clocks appended after each frame.
- FIFO_DEPTH, 16: entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe; sampled at rising edge.
- wr_data  input  DATA_SIZE  word to enqueue.
- full  output  1  FIFO holds FIFO_DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  one-cycle pulse when wr_en is dropped because full=1.
- busy  output  1  state != IDLE.
- tx_start  output  1  one-cycle pulse to UART TX_START.
- tx_data  output  DATA_SIZE  word to UART data_in.

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, busy=0, state=IDLE, frame timer=0. All outputs are registered.
- FRAME_CLKS = CLKS_PER_BIT*(1+DATA_SIZE+STOP_BITS)+GAP_CLKS.
- FIFO write:
  - wr_en=1 and full=0: store wr_data at write pointer, advance pointer modulo FIFO_DEPTH.
  - wr_en=1 and full=1: drop the word and pulse overflow. full is the registered value from the prior cycle, so a same-cycle pop does not rescue the write.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Pointers wrap at FIFO_DEPTH. full/empty derive from count, never from pointer equality alone.
- State machine:
  - IDLE: if empty=0, go to LOAD; otherwise stay.
  - LOAD (1 cycle): tx_data <= head word; pop (read pointer++, count-- unless a write is simultaneously accepted); go to SEND; load timer with FRAME_CLKS-1.
  - SEND: tx_start=1 in the first SEND cycle only. Timer decrements each cycle; at timer=0, go to IDLE.
- tx_data holds from LOAD until the next LOAD; it is never changed mid-frame.
- Timing:
  - Back-to-back tx_start period = FRAME_CLKS+2 cycles (SEND + IDLE + LOAD).
  - Latency: a write accepted at edge k into an empty IDLE FIFO gives LOAD after edge k+1 and tx_start high after edge k+2.
- Writes are accepted in every state; busy has no effect on the write side.
- Reset asserted mid-SEND aborts immediately. FIFO contents are discarded and tx_start cannot pulse again until a fresh write after reset release.
- count width is sufficient to represent FIFO_DEPTH exactly; no arithmetic overflow is possible.

Test Plan:
- Reset values: hold reset=0 for 3 cycles, release -> empty=1, full=0, count=0, busy=0, tx_start=0, tx_data=0.
- Single word (CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, DATA_SIZE=7, STOP_BITS=1, GAP_CLKS=0, so FRAME_CLKS=90): write 7'h55 at edge 0 -> tx_start high exactly one cycle after edge 2; tx_data=7'h55; busy drops after 92 cycles total.
- Burst ordering (same params): write 7'h01, 7'h02, 7'h03 on consecutive cycles -> three tx_start pulses spaced 92 cycles apart, tx_data 01, 02, 03 in order; final empty=1.
- Overflow (FIFO_DEPTH=4, BAUD slow): write 5 words with no pop possible -> count=4, full=1, overflow pulses once on the 5th write; 5th word is never transmitted.
- Wrap-around: 10 writes interleaved with pops through a depth-4 FIFO -> all 10 words transmitted in order, no loss, count returns to 0.
- Reset mid-frame: assert reset 20 cycles into SEND with 2 words queued -> all outputs at reset values within the same cycle; no further tx_start after release until a new write.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// Host write port and UART-side outputs of uart_tx_feeder.
// master drives writes; slave is the feeder itself.
interface uart_tx_feeder_if #(
  parameter int DATA_SIZE  = 7,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 busy;
  logic                 tx_start;
  logic [DATA_SIZE-1:0] tx_data;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow,
    input  busy, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow,
    output busy, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// FIFO-buffered UART transmit feeder.
// Paces tx_start pulses with a local frame timer.
module uart_tx_feeder #(
  parameter int DATA_SIZE   = 7,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int STOP_BITS   = 1,
  parameter int GAP_CLKS    = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  bus
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int FRAME_CLKS =
    CPB * (1 + DATA_SIZE + STOP_BITS) + GAP_CLKS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FRAME_CLKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t               state_q;
  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        rptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 full_q;
  logic                 empty_q;
  logic                 ovf_q;
  logic [TW-1:0]        timer_q;
  logic [DATA_SIZE-1:0] data_q;
  logic                 start_q;
  logic                 busy_q;
  logic                 push;
  logic                 pop;

  // full is last cycle's value, so a same-cycle pop never rescues a write
  assign push = bus.wr_en && !full_q;
  assign pop  = (state_q == LOAD);

  // next occupancy; push and pop together leave it unchanged
  always_comb begin
    count_d = count_q;
    count_d = count_d + {{(CW-1){1'b0}}, push};
    count_d = count_d - {{(CW-1){1'b0}}, pop};
  end

  // FIFO pointers, occupancy flags and overflow pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= bus.wr_en && full_q;
    end
  end

  // storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wr_data;
  end

  // frame sequencer with registered tx_start/tx_data/busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty_q) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          data_q  <= mem_q[rptr_q];
          timer_q <= TW'(FRAME_CLKS - 1);
          start_q <= 1'b1;
          state_q <= SEND;
          busy_q  <= 1'b1;
        end
        SEND: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
endmodule
